// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds PS/2 Scan Code Set 2 prefix sequences (E0, F0,
// E1 pause) into single key events and queues them in a small FWFT FIFO.
// It also tracks live modifier state: {caps_lock, alt, ctrl, shift}.
// Optional feature macro: PS2_ASCII_EN adds a per-event translated character.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic       enable_in,
  input  logic [7:0] data_in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [7:0] event_code,
  output logic       event_break,
  output logic       event_ext,
`ifdef PS2_ASCII_EN
  output logic [7:0] event_ascii,
`endif
  output logic [3:0] modifiers,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef PS2_ASCII_EN
  localparam int unsigned EW = 18;
`else
  localparam int unsigned EW = 10;
`endif

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_EXT       = 5'b00010,
    S_BREAK     = 5'b00100,
    S_EXT_BREAK = 5'b01000,
    S_PAUSE     = 5'b10000
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic          lalt_q, lalt_d, ralt_q, ralt_d;
  logic          caps_q, caps_d, caps_held_q, caps_held_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic          ev_push, ev_brk, ev_ext, ev_valid;
  logic [7:0]    ev_code;
  logic          pop, full, accept;
  logic [EW-1:0] entry, head;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_of = 8'h61; 8'h32: letter_of = 8'h62; 8'h21: letter_of = 8'h63;
      8'h23: letter_of = 8'h64; 8'h24: letter_of = 8'h65; 8'h2B: letter_of = 8'h66;
      8'h34: letter_of = 8'h67; 8'h33: letter_of = 8'h68; 8'h43: letter_of = 8'h69;
      8'h3B: letter_of = 8'h6A; 8'h42: letter_of = 8'h6B; 8'h4B: letter_of = 8'h6C;
      8'h3A: letter_of = 8'h6D; 8'h31: letter_of = 8'h6E; 8'h44: letter_of = 8'h6F;
      8'h4D: letter_of = 8'h70; 8'h15: letter_of = 8'h71; 8'h2D: letter_of = 8'h72;
      8'h1B: letter_of = 8'h73; 8'h2C: letter_of = 8'h74; 8'h3C: letter_of = 8'h75;
      8'h2A: letter_of = 8'h76; 8'h1D: letter_of = 8'h77; 8'h22: letter_of = 8'h78;
      8'h35: letter_of = 8'h79; 8'h1A: letter_of = 8'h7A;
      default: letter_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic brk, input logic shift,
                                          input logic caps);
    logic [7:0] l;
    l = letter_of(code);
    ascii_of = 8'h00;
    if (brk) begin
      ascii_of = 8'h00;
    end else if (ext) begin
      case (code)
        8'h4A:   ascii_of = 8'h2F;
        8'h5A:   ascii_of = 8'h0D;
        default: ascii_of = 8'h00;
      endcase
    end else if (l != 8'h00) begin
      ascii_of = (shift ^ caps) ? (l - 8'h20) : l;
    end else begin
      case (code)
        8'h16: ascii_of = shift ? 8'h21 : 8'h31;
        8'h1E: ascii_of = shift ? 8'h40 : 8'h32;
        8'h26: ascii_of = shift ? 8'h23 : 8'h33;
        8'h25: ascii_of = shift ? 8'h24 : 8'h34;
        8'h2E: ascii_of = shift ? 8'h25 : 8'h35;
        8'h36: ascii_of = shift ? 8'h5E : 8'h36;
        8'h3D: ascii_of = shift ? 8'h26 : 8'h37;
        8'h3E: ascii_of = shift ? 8'h2A : 8'h38;
        8'h46: ascii_of = shift ? 8'h28 : 8'h39;
        8'h45: ascii_of = shift ? 8'h29 : 8'h30;
        8'h29: ascii_of = 8'h20;
        8'h5A: ascii_of = 8'h0D;
        8'h66: ascii_of = 8'h08;
        8'h0D: ascii_of = 8'h09;
        8'h76: ascii_of = 8'h1B;
        default: ascii_of = 8'h00;
      endcase
    end
  endfunction
`endif

  // Prefix-sequence FSM: decides next state and whether a byte completes an event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_push = 1'b0;
    ev_code = data_in;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (enable_in) begin
      case (state_q)
        S_IDLE: begin
          if (data_in == 8'hE0) begin
            state_d = S_EXT;
          end else if (data_in == 8'hF0) begin
            state_d = S_BREAK;
          end else if (data_in == 8'hE1) begin
            state_d = S_PAUSE;
            cnt_d   = 3'd7;
          end else if (data_in == 8'h00 || data_in == 8'hAA || data_in == 8'hEE ||
                       data_in == 8'hFA || data_in == 8'hFE || data_in == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            ev_push = 1'b1;
          end
        end
        S_EXT: begin
          if (data_in == 8'hF0) begin
            state_d = S_EXT_BREAK;
          end else begin
            ev_push = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BREAK: begin
          ev_push = 1'b1;
          ev_brk  = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BREAK: begin
          ev_push = 1'b1;
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            ev_push = 1'b1;
            ev_code = 8'hE1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // E0-prefixed 12/59 are fake shifts: neither queued nor applied to modifiers.
  assign ev_valid = ev_push && !(ev_ext && (ev_code == 8'h12 || ev_code == 8'h59));

  // Modifier and held-key tracking, updated on every decoded event.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (ev_valid) begin
      if (!ev_ext) begin
        case (ev_code)
          8'h12: lshift_d = !ev_brk;
          8'h59: rshift_d = !ev_brk;
          8'h14: lctrl_d  = !ev_brk;
          8'h11: lalt_d   = !ev_brk;
          8'h58: begin
            caps_held_d = !ev_brk;
            if (!ev_brk && !caps_held_q) caps_d = !caps_q;
          end
          default: ;
        endcase
      end else begin
        case (ev_code)
          8'h14:   rctrl_d = !ev_brk;
          8'h11:   ralt_d  = !ev_brk;
          default: ;
        endcase
      end
    end
  end

  assign modifiers = {caps_q, lalt_q | ralt_q, lctrl_q | rctrl_q, lshift_q | rshift_q};

  // FIFO control: a pop in the same cycle frees room for a push when full.
  always_comb begin
    pop        = event_ready && (count_q != '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    accept     = ev_valid && (!full || pop);
    overflow_d = ev_valid && full && !pop;
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(accept) - CW'(pop);
  end

`ifdef PS2_ASCII_EN
  assign entry = {ascii_of(ev_code, ev_ext, ev_brk, lshift_q | rshift_q, caps_q),
                  ev_ext, ev_brk, ev_code};
`else
  assign entry = {ev_ext, ev_brk, ev_code};
`endif

  // Storage array is reset-free; outputs are gated by event_valid instead.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= entry;
  end

  assign head        = mem[rd_ptr_q];
  assign event_valid = (count_q != '0);
  assign event_code  = event_valid ? head[7:0] : '0;
  assign event_break = event_valid ? head[8] : 1'b0;
  assign event_ext   = event_valid ? head[9] : 1'b0;
`ifdef PS2_ASCII_EN
  assign event_ascii = event_valid ? head[17:10] : '0;
`endif
  assign overflow    = overflow_q;

  // State, modifier and FIFO-pointer registers with async and sync clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || sync_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder (FIFO_DEPTH = 4).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [7:0] event_code;
  logic       event_break;
  logic       event_ext;
`ifdef PS2_ASCII_EN
  logic [7:0] event_ascii;
`endif
  logic [3:0] modifiers;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .enable_in  (enable_in),
    .data_in    (data_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_code (event_code),
    .event_break(event_break),
    .event_ext  (event_ext),
`ifdef PS2_ASCII_EN
    .event_ascii(event_ascii),
`endif
    .modifiers  (modifiers),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    enable_in = 1'b1;
    data_in   = b;
    @(negedge clk);
    enable_in = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  // Head event as {valid, ext, break, code}.
  function automatic logic [31:0] head();
    return {21'd0, event_valid, event_ext, event_break, event_code};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", event_valid, 0);
    check("reset_code", event_code, 0);
    check("reset_mods", modifiers, 0);
    check("reset_ovf", overflow, 0);
    reset_n = 1'b1;

    // Plain make then break
    send(8'h1C);
    check("make_1C", head(), 32'h41C);
`ifdef PS2_ASCII_EN
    check("ascii_a", event_ascii, 8'h61);
`endif
    pop1();
    send(8'hF0); send(8'h1C);
    check("break_1C", head(), 32'h51C);
`ifdef PS2_ASCII_EN
    check("ascii_break", event_ascii, 8'h00);
`endif
    pop1();
    check("empty_1", event_valid, 0);

    // Shifted letter
    send(8'h12);
    check("shift_on", modifiers, 4'b0001);
    send(8'h1C);
    send(8'hF0); send(8'h12);
    check("shift_off", modifiers, 4'b0000);
    check("lshift_make", head(), 32'h412);
    pop1();
    check("shifted_1C", head(), 32'h41C);
`ifdef PS2_ASCII_EN
    check("ascii_A", event_ascii, 8'h41);
`endif
    pop1();
    check("lshift_break", head(), 32'h512);
    pop1();
    check("empty_2", event_valid, 0);

    // Fake shifts around extended key
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    send(8'hE0); send(8'hF0); send(8'h7C); send(8'hE0); send(8'hF0); send(8'h12);
    check("fake_shift_mods", modifiers, 0);
    check("ext_make_7C", head(), 32'h67C);
    pop1();
    check("ext_break_7C", head(), 32'h77C);
    pop1();
    check("empty_3", event_valid, 0);

    // Pause sequence
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    check("pause_pending", event_valid, 0);
    send(8'h77);
    check("pause_event", head(), 32'h6E1);
    check("pause_mods", modifiers, 0);
    pop1();
    check("empty_4", event_valid, 0);

    // Overflow with FIFO full
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("full_no_ovf", overflow, 0);
    send(8'h24);
    check("ovf_pulse", overflow, 1);
    @(negedge clk);
    check("ovf_one_cycle", overflow, 0);
    check("full_head", head(), 32'h41C);
    @(negedge clk);
    enable_in = 1'b1; data_in = 8'h2B; event_ready = 1'b1;
    @(negedge clk);
    enable_in = 1'b0; event_ready = 1'b0;
    check("push_pop_full_ovf", overflow, 0);
    check("after_pp_32", head(), 32'h432);
    pop1(); check("drain_21", head(), 32'h421);
    pop1(); check("drain_23", head(), 32'h423);
    pop1(); check("drain_2B", head(), 32'h42B);
    pop1(); check("empty_5", event_valid, 0);

    // Simultaneous push and pop at count=1
    send(8'h1C);
    @(negedge clk);
    enable_in = 1'b1; data_in = 8'h32; event_ready = 1'b1;
    @(negedge clk);
    enable_in = 1'b0; event_ready = 1'b0;
    check("pp_count1", head(), 32'h432);
    pop1();
    check("empty_6", event_valid, 0);

    // Caps lock with typematic repeats; events drained continuously
    event_ready = 1'b1;
    send(8'h58);
    check("caps_on", modifiers, 4'b1000);
    send(8'h58); send(8'h58);
    check("caps_repeat", modifiers, 4'b1000);
    send(8'hF0); send(8'h58);
    check("caps_break", modifiers, 4'b1000);
    send(8'h58);
    check("caps_off", modifiers, 4'b0000);
    @(negedge clk);
    event_ready = 1'b0;
    check("empty_7", event_valid, 0);

    // Extended ctrl/alt hold and release
    send(8'hE0); send(8'h14); send(8'hE0); send(8'h11);
    check("rctrl_ralt", modifiers, 4'b0110);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("ralt_only", modifiers, 4'b0100);
    @(negedge clk);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    check("sync_rst_mods", modifiers, 0);
    check("sync_rst_valid", event_valid, 0);

    // Async reset mid-sequence
    send(8'hE0);
    reset_n = 1'b0;
    #1;
    check("arst_valid", event_valid, 0);
    check("arst_mods", modifiers, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h1C);
    check("post_rst_1C", head(), 32'h41C);
    pop1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 keyboard receiver (one-cycle `enable_in` strobe plus `data_in`) and folds Scan Code Set 2 prefix sequences (E0, F0, E1 pause) into single key events. Each event carries a make/break flag and an extended flag. Events are queued in a small FIFO with a valid/ready output handshake. The block tracks modifier state for software or downstream ASCII logic, and sits between the PS/2 receiver and the CPU-side peripheral register bank.

## Interface
- `FIFO_DEPTH`, default 4: event queue depth; power of two, 2..16.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous active-low reset.
- `sync_reset`  in  1: synchronous clear; same effect as reset, one cycle.
- `enable_in`  in  1: one-cycle byte strobe from the receiver.
- `data_in`  in  8: received byte, valid with `enable_in`.
- `event_valid`  out  1: FIFO non-empty.
- `event_ready`  in  1: consumer pops the head event when high with `event_valid`.
- `event_code`  out  8: final scancode byte of the head event.
- `event_break`  out  1: 1 = key release (F0 seen).
- `event_ext`  out  1: 1 = E0-prefixed or pause event.
- `event_ascii`  out  8: translated character; present only with `PS2_ASCII_EN`.
- `modifiers`  out  4: {caps_lock, alt, ctrl, shift}; live state.
- `overflow`  out  1: one-cycle pulse when an event is dropped because the FIFO is full.
- Reset values: `event_valid`=0, `event_code`/`event_break`/`event_ext`/`event_ascii`=0, `modifiers`=0, `overflow`=0.

## Operation
- One-hot FSM with states S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK, S_PAUSE. It advances only on cycles with `enable_in`=1.
- S_IDLE:
  - E0 -> S_EXT.
  - F0 -> S_BREAK.
  - E1 -> S_PAUSE, loading the skip counter with 7.
  - 00, AA, EE, FA, FE, FF are swallowed (error, BAT, echo, ack, resend); stay.
  - Any other byte -> push {code, break=0, ext=0}; stay.
- S_EXT:
  - F0 -> S_EXT_BREAK.
  - Other byte -> push {code, 0, 1}; -> S_IDLE.
- S_BREAK: any byte -> push {code, 1, 0}; -> S_IDLE.
- S_EXT_BREAK: any byte -> push {code, 1, 1}; -> S_IDLE.
- S_PAUSE:
  - Each byte decrements the 3-bit counter.
  - When the counter reaches 0, push {E1, 0, 1} and go to S_IDLE. A full pause sequence therefore yields exactly one event.
- Fake-shift events are never pushed: ext=1 with code 12 or 59, either polarity. These also do not touch the modifiers.
- Modifier update happens when the event is decoded, independent of FIFO space:
  - shift = lshift(12) | rshift(59).
  - ctrl = lctrl(14) | rctrl(E0 14).
  - alt = lalt(11) | ralt(E0 11).
  - Each key is held on make and cleared on break.
  - caps_lock toggles on make of 58 only while the 58 key is not already held. A held-key tracker means typematic repeats do not toggle.
- FIFO:
  - Circular buffer with wrap-around pointers and a count.
  - Head is presented combinationally (first-word fall-through).
  - Push when full is dropped and `overflow` pulses, unless a pop occurs in the same cycle, in which case the push is accepted.
  - Pop when empty is ignored.
- `sync_reset` or `reset_n` mid-sequence returns the FSM to S_IDLE and clears the counter, FIFO, modifiers and key trackers.

## Timing
- Byte strobe at cycle N -> FSM, modifiers and FIFO update on the edge ending N. `event_valid` is high in N+1, so latency is 1 clock.
- Back-to-back `enable_in` on consecutive cycles is accepted, one byte per cycle.
- Pop at cycle M -> next head or `event_valid`=0 in M+1.
- Simultaneous push and pop at count=1 keeps `event_valid` high with the new event in M+1.
- `overflow` is asserted in the cycle after the dropped push.

## Configuration
- `PS2_ASCII_EN` defined:
  - `event_ascii` port exists and is stored per entry (FIFO width 18).
  - Translation is computed at push time from code, current shift, and caps_lock. caps_lock affects letters only.
  - Required mappings:
    - Letters: 1C -> 61 / 41 (shifted).
    - Digits: 16 -> 31 / 21 (shifted).
    - Controls: 29 -> 20, 5A -> 0D, 66 -> 08, 0D -> 09, 76 -> 1B.
    - Extended: E0 4A -> 2F, E0 5A -> 0D.
  - Break events, other extended codes, and unmapped codes give 00.
- Undefined: no `event_ascii` port, FIFO width 10, no translation logic.

## Test plan
- Bytes 1C then F0 1C -> events {1C,0,0} then {1C,1,0}. With ASCII: 61 then 00.
- 12, 1C, F0 12 -> shift=1 during the 1C event; ASCII 41; shift=0 afterwards.
- E0 12 E0 7C, then E0 F0 7C E0 F0 12 -> only {7C,0,1} and {7C,1,1} queued; shift stays 0.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,1}; ctrl stays 0.
- `event_ready`=0 with FIFO_DEPTH+1 make codes -> 4 events held, one `overflow` pulse. Pop with a simultaneous push when full -> no overflow.
- 58 make x3 (typematic), then F0 58, then 58 -> caps_lock 1 after the first make, still 1 after the repeats and break, 0 after the final make. Assert `reset_n` after E0 and before the next byte -> all outputs 0; a following 1C decodes as {1C,0,0}.
